// File: rtl/apb_wdt.sv
// Purpose : APB watchdog timer; IDLE->RUN->BARK->BITE countdown with kick, bark irq and bite reset request.
// Latency : zero-wait-state APB; wdt_irq / wdt_rst_req are registered, one clk after the status that drives them.
// Backpr. : none; pready is high in every access phase, no transfer is ever stalled.
//
// Ports   : clk, rstn (async active-low); APB responder psel/penable/paddr/pwrite/pstrb/pwdata ->
//           prdata/pslverr/pready; wdt_irq (bark level), wdt_rst_req (bite level).
// Map     : 0x00 CTRL {RST_EN,IRQ_EN,EN}, 0x04 LOAD, 0x08 COUNT (RO), 0x0C KICK (WO key),
//           0x10 STATUS {state[1:0], BARK(W1C)}, 0x14 LOCK (only with `define WDT_LOCK_EN).
module apb_wdt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [3:0]  pstrb,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        pready,
    output logic        wdt_irq,
    output logic        wdt_rst_req
);

    localparam logic [31:0] KICK_KEY = 32'h5A5A_5A5A;
    localparam logic [31:0] LOCK_KEY = 32'h1ACC_E551;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BARK = 2'd2,
        ST_BITE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  ctrl, ctrl_nxt;
    logic [31:0] load, load_eff;
    logic [31:0] count;
    logic        bark;
    logic        locked;

    logic        acc;
    logic [31:0] rd_val;
    logic        err, ctrl_we, load_we, kick_ok, stat_we, lock_we;
    logic        reload, dec, bark_set;
    logic        irq_d, rst_d;

    // Only the low address byte is decoded.
    logic unused_addr;
    assign unused_addr = ^paddr[31:8];

    assign acc    = psel & penable;
    assign pready = acc;

    // Bus decode: all side effects are qualified by the access phase.
    always_comb begin
        err     = 1'b0;
        rd_val  = '0;
        ctrl_we = 1'b0;
        load_we = 1'b0;
        kick_ok = 1'b0;
        stat_we = 1'b0;
        lock_we = 1'b0;
        if (acc) begin
            case (paddr[7:0])
                8'h00: begin
                    if (!pwrite)     rd_val = {29'd0, ctrl};
                    else if (locked) err = 1'b1;
                    else             ctrl_we = 1'b1;
                end
                8'h04: begin
                    if (!pwrite)     rd_val = load;
                    else if (locked) err = 1'b1;
                    else             load_we = 1'b1;
                end
                8'h08: begin
                    if (pwrite) err = 1'b1;
                    else        rd_val = count;
                end
                8'h0C: begin
                    if (!pwrite || pstrb != 4'hf || pwdata != KICK_KEY) err = 1'b1;
                    else                                                  kick_ok = 1'b1;
                end
                8'h10: begin
                    if (pwrite) stat_we = 1'b1;
                    else        rd_val = {29'd0, state, bark};
                end
`ifdef WDT_LOCK_EN
                8'h14: begin
                    if (pwrite) lock_we = 1'b1;
                    else        rd_val = {31'd0, locked};
                end
`endif
                default: err = 1'b1;
            endcase
        end
    end

    // Error reads return zero because rd_val is never loaded on an error path.
    assign prdata  = rstn ? rd_val : '0;
    assign pslverr = rstn & err;

    // EN is frozen once bitten; the enable bits still take writes.
    always_comb begin
        ctrl_nxt = ctrl;
        if (ctrl_we && pstrb[0]) begin
            ctrl_nxt = pwdata[2:0];
            if (state == ST_BITE) ctrl_nxt[0] = ctrl[0];
        end
    end

    assign load_eff = (load == '0) ? 32'd1 : load;

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state. Priority in RUN/BARK is disable > kick > expiry.
    always_comb begin
        state_nxt = state;
        reload    = 1'b0;
        dec       = 1'b0;
        bark_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ctrl[0] && ctrl_nxt[0]) begin
                    state_nxt = ST_RUN;
                    reload    = 1'b1;
                end
            end
            ST_RUN, ST_BARK: begin
                if (ctrl[0] && !ctrl_nxt[0]) begin
                    state_nxt = ST_IDLE;
                end else if (kick_ok) begin
                    state_nxt = ST_RUN;
                    reload    = 1'b1;
                end else if (count == '0) begin
                    reload = 1'b1;
                    if (state == ST_RUN) begin
                        state_nxt = ST_BARK;
                        bark_set  = 1'b1;
                    end else begin
                        state_nxt = ST_BITE;
                    end
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_nxt = ST_BITE;
        endcase
    end

    // FSM: outputs (registered below)
    always_comb begin
        irq_d = bark & ctrl[1];
        rst_d = (state == ST_BITE) & ctrl[2];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_irq     <= 1'b0;
            wdt_rst_req <= 1'b0;
        end else begin
            wdt_irq     <= irq_d;
            wdt_rst_req <= rst_d;
        end
    end

    // Register file and counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl  <= '0;
            load  <= 32'hFFFF_FFFF;
            count <= 32'hFFFF_FFFF;
            bark  <= 1'b0;
        end else begin
            ctrl <= ctrl_nxt;
            for (int i = 0; i < 4; i++) begin
                if (load_we && pstrb[i]) load[8*i +: 8] <= pwdata[8*i +: 8];
            end
            if (reload)   count <= load_eff;
            else if (dec) count <= count - 32'd1;
            // A new bark outranks a simultaneous W1C.
            if (bark_set)                           bark <= 1'b1;
            else if (stat_we && pstrb[0] && pwdata[0]) bark <= 1'b0;
        end
    end

`ifdef WDT_LOCK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        locked <= 1'b0;
        else if (lock_we) locked <= (pwdata != LOCK_KEY);
    end
`else
    assign locked = 1'b0;
    logic unused_lock;
    assign unused_lock = lock_we ^ (^LOCK_KEY);
`endif

endmodule

// File: tb/tb_apb_wdt.sv
// Purpose : self-checking bench for apb_wdt: register table plus timed watchdog sequences.
// Latency : n/a
// Backpr. : n/a
module tb_apb_wdt;

    logic        clk = 1'b0;
    logic        rstn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pslverr, pready, wdt_irq, wdt_rst_req;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] KEY = 32'h5A5A_5A5A;
`ifdef WDT_LOCK_EN
    localparam logic LOCK_ERR = 1'b0;
`else
    localparam logic LOCK_ERR = 1'b1;
`endif

    apb_wdt dut (
        .clk(clk), .rstn(rstn),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
        .pready(pready), .wdt_irq(wdt_irq), .wdt_rst_req(wdt_rst_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One APB transfer; commits on the third posedge after the call.
    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
        @(negedge clk);
        chk("setup_pready", {31'd0, pready}, 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rd  = prdata;
        err = pslverr;
        chk("access_pready", {31'd0, pready}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic e;
        apb(1'b1, a, d, 4'hf, r, e);
        chk($sformatf("wr_ok_%02h", a[7:0]), {31'd0, e}, 32'd0);
    endtask

    task automatic wr_err(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic e;
        apb(1'b1, a, d, 4'hf, r, e);
        chk($sformatf("wr_err_%02h", a[7:0]), {31'd0, e}, 32'd1);
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        apb(1'b0, a, 32'd0, 4'h0, r, e);
        chk({nm, "_err"}, {31'd0, e}, 32'd0);
        chk(nm, r, exp);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h00,  32'h0,         4'h0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h04,  32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{1'b0, 32'h08,  32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{1'b0, 32'h10,  32'h0,         4'h0, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h04,  32'h1234_5678, 4'hf, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'h04,  32'h0,         4'h0, 32'h1234_5678, 1'b0};
        vecs[6]  = '{1'b1, 32'h04,  32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h04,  32'h0,         4'h0, 32'h12BB_56DD, 1'b0};
        vecs[8]  = '{1'b1, 32'h00,  32'h6,         4'he, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h00,  32'h0,         4'h0, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 32'h00,  32'h6,         4'h1, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h00,  32'h0,         4'h0, 32'h6,         1'b0};
        vecs[12] = '{1'b1, 32'h08,  32'h0,         4'hf, 32'h0,         1'b1};
        vecs[13] = '{1'b0, 32'h0C,  32'h0,         4'h0, 32'h0,         1'b1};
        vecs[14] = '{1'b1, 32'h0C,  32'h1234_5678, 4'hf, 32'h0,         1'b1};
        vecs[15] = '{1'b1, 32'h0C,  KEY,           4'h3, 32'h0,         1'b1};
        vecs[16] = '{1'b0, 32'h20,  32'h0,         4'h0, 32'h0,         1'b1};
        vecs[17] = '{1'b0, 32'h14,  32'h0,         4'h0, 32'h0,         LOCK_ERR};
        vecs[18] = '{1'b1, 32'h0C,  KEY,           4'hf, 32'h0,         1'b0};
        vecs[19] = '{1'b0, 32'h08,  32'h0,         4'h0, 32'hFFFF_FFFF, 1'b0};
        vecs[20] = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h12BB_56DD, 1'b0};
        vecs[21] = '{1'b1, 32'h03,  32'h0,         4'hf, 32'h0,         1'b1};
        vecs[22] = '{1'b1, 32'h00,  32'h0,         4'hf, 32'h0,         1'b0};
        vecs[23] = '{1'b0, 32'h00,  32'h0,         4'h0, 32'h0,         1'b0};
        vecs[24] = '{1'b0, 32'h10,  32'h0,         4'h0, 32'h0,         1'b0};

        rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq",     {31'd0, wdt_irq},     32'd0);
        chk("rst_rst_req", {31'd0, wdt_rst_req}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr},     32'd0);
        chk("rst_prdata",  prdata,               32'd0);
        chk("rst_pready",  {31'd0, pready},      32'd0);
        rstn = 1'b1;

        // Register map, byte lanes and error responses while IDLE.
        for (int i = 0; i < NV; i++) begin
            logic [31:0] r;
            logic e;
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, r, e);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
        end

        // LOAD written while running only affects the next reload.
        wr(32'h04, 32'd50);
        wr(32'h00, 32'h1);
        wr(32'h04, 32'd7);
        rd("count_after_load_wr", 32'h08, 32'd45);
        wr(32'h0C, KEY);
        rd("count_after_kick", 32'h08, 32'd5);

        // Periodic kicks hold RUN; a kick exactly at COUNT==0 wins.
        wr(32'h00, 32'h0);
        wr(32'h04, 32'd4);
        wr(32'h00, 32'h3);
        for (int k = 0; k < 5; k++) begin
            wr(32'h0C, KEY);
            chk("kick_irq", {31'd0, wdt_irq}, 32'd0);
        end
        repeat (2) @(posedge clk);
        wr(32'h0C, KEY);
        wr(32'h00, 32'h0);
        rd("kick_zero_status", 32'h10, 32'h0);
        rd("idle_count_hold", 32'h08, 32'd2);

        // W1C of BARK in BARK, then disable: IDLE with COUNT frozen.
        wr(32'h04, 32'd14);
        wr(32'h00, 32'h3);
        repeat (15) @(posedge clk);
        wr(32'h10, 32'h1);
        @(posedge clk); #1;
        chk("w1c_irq", {31'd0, wdt_irq}, 32'd0);
        rd("w1c_status", 32'h10, 32'h4);
        wr(32'h00, 32'h0);
        rd("frozen_count_a", 32'h08, 32'd5);
        rd("frozen_count_b", 32'h08, 32'd5);
        rd("frozen_status", 32'h10, 32'h0);

        // Full bark/bite timeline with LOAD=4.
        wr(32'h04, 32'd4);
        wr(32'h00, 32'h7);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            chk($sformatf("tl_irq_c%0d", k), {31'd0, wdt_irq}, {31'd0, k >= 6});
            chk($sformatf("tl_rst_c%0d", k), {31'd0, wdt_rst_req}, {31'd0, k >= 11});
        end
        rd("bite_status", 32'h10, 32'h7);
        wr(32'h0C, KEY);
        wr(32'h00, 32'h6);
        rd("bite_ctrl", 32'h00, 32'h7);
        rd("bite_status2", 32'h10, 32'h7);
        chk("bite_rst_hold", {31'd0, wdt_rst_req}, 32'd1);

        // Reset during an access phase aborts the LOAD write.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04;
        pwdata = 32'h1111_1111; pstrb = 4'hf;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_irq",     {31'd0, wdt_irq},     32'd0);
        chk("mid_rst_rst_req", {31'd0, wdt_rst_req}, 32'd0);
        chk("mid_rst_pslverr", {31'd0, pslverr},     32'd0);
        chk("mid_rst_prdata",  prdata,               32'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        rstn = 1'b1;
        rd("post_rst_load",   32'h04, 32'hFFFF_FFFF);
        rd("post_rst_status", 32'h10, 32'h0);
        rd("post_rst_ctrl",   32'h00, 32'h0);
        rd("post_rst_count",  32'h08, 32'hFFFF_FFFF);

        // LOAD==0 acts as 1: two cycles per stage.
        wr(32'h04, 32'd0);
        wr(32'h00, 32'h7);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("min_irq_c%0d", k), {31'd0, wdt_irq}, {31'd0, k >= 3});
            chk($sformatf("min_rst_c%0d", k), {31'd0, wdt_rst_req}, {31'd0, k >= 5});
        end

`ifdef WDT_LOCK_EN
        pulse_reset();
        wr(32'h14, 32'h0);
        wr_err(32'h00, 32'h1);
        rd("locked_ctrl", 32'h00, 32'h0);
        rd("lock_state", 32'h14, 32'h1);
        wr(32'h0C, KEY);
        wr(32'h14, 32'h1ACC_E551);
        rd("unlock_state", 32'h14, 32'h0);
        wr(32'h00, 32'h1);
        rd("unlocked_status", 32'h10, 32'h2);
`else
        pulse_reset();
        rd("nolock_ctrl", 32'h00, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_wdt.md
APB_WDT -- requirements
Module: apb_wdt

Interface
REQ-001 SHALL have ports: clk in 1, single clock; rstn in 1, asynchronous active-low reset.
REQ-002 SHALL have APB responder ports: psel in 1; penable in 1; paddr in 32; pwrite in 1; pstrb in 4; pwdata in 32; prdata out 32; pslverr out 1; pready out 1.
REQ-003 SHALL have outputs: wdt_irq out 1, bark interrupt level; wdt_rst_req out 1, bite reset request level.

Function
REQ-004 SHALL decode paddr[7:0] only: 0x00 CTRL (RW; bit0 EN, bit1 IRQ_EN, bit2 RST_EN), 0x04 LOAD (RW, 32b), 0x08 COUNT (RO), 0x0C KICK (WO, key 0x5A5A_5A5A), 0x10 STATUS (bit0 BARK W1C, bits[2:1] state RO).
REQ-005 SHALL complete every transfer with zero wait states: pready=1 whenever psel&penable, else 0.
REQ-006 SHALL commit writes and sample reads only in the access phase (psel&penable&pready); setup phase has no side effect.
REQ-007 SHALL honour pstrb byte lanes for CTRL and LOAD writes; reads return the full 32b.
REQ-008 SHALL assert pslverr for one access cycle, with no state change, on: unmapped offset; write to COUNT; read of KICK; KICK write with pstrb!=4'hf or wrong key.
REQ-009 SHALL return prdata=0 on non-access cycles and error reads.
REQ-010 SHALL implement FSM IDLE(0)->RUN(1)->BARK(2)->BITE(3), encoded in STATUS[2:1].
REQ-011 IDLE: COUNT holds; an EN 0->1 write loads COUNT<=LOAD and enters RUN next cycle.
REQ-012 RUN/BARK: COUNT decrements by 1 each clk; when COUNT==0 it reloads from LOAD on the same edge.
REQ-013 RUN at COUNT==0 -> BARK, set STATUS.BARK; BARK at COUNT==0 -> BITE.
REQ-014 LOAD==0 SHALL be treated as 1, giving minimum period of 2 cycles per stage.
REQ-015 A valid KICK in RUN or BARK SHALL reload COUNT<=LOAD and return to RUN; STATUS.BARK is unaffected.
REQ-016 KICK coincident with COUNT==0 SHALL win: reload, no transition.
REQ-017 EN cleared in RUN or BARK SHALL enter IDLE next cycle, with COUNT holding.
REQ-018 BITE SHALL be sticky: exit only by rstn; KICK and EN writes are ignored there without error.
REQ-019 wdt_irq = STATUS.BARK & IRQ_EN, registered; W1C of BARK and IRQ_EN write coincident: IRQ_EN takes the new value, BARK clears.
REQ-020 wdt_rst_req = (state==BITE) & RST_EN, registered; 1-cycle latency from entry to BITE.
REQ-021 A LOAD write during RUN SHALL affect only the next reload; the current COUNT is unchanged.

Reset
REQ-022 On rstn low, asynchronously: CTRL=0, LOAD=0xFFFF_FFFF, COUNT=0xFFFF_FFFF, STATUS=0, state=IDLE, wdt_irq=0, wdt_rst_req=0, pslverr=0, prdata=0.
REQ-023 Reset mid-transfer SHALL abort it with no register update; the first access after release is serviced normally.

Configuration
REQ-024 Macro WDT_LOCK_EN: when defined, add LOCK at 0x14 (RW; reads bit0=locked); reset value is locked=0.
REQ-025 With WDT_LOCK_EN: writing 0x1ACC_E551 to LOCK clears the lock; any other LOCK write sets it. While locked, CTRL and LOAD writes return pslverr with no update; KICK is still allowed.
REQ-026 Without WDT_LOCK_EN: offset 0x14 is unmapped (pslverr), and CTRL and LOAD are always writable.

Verification
REQ-027 Write LOAD=4, CTRL=0x7 -> RUN; BARK 5 cycles after EN commit; wdt_irq=1 one cycle later; BITE 5 cycles after BARK; wdt_rst_req=1 next cycle.
REQ-028 LOAD=4, EN; KICK 0x5A5A_5A5A every 3 cycles -> STATUS[2:1] stays 1 and wdt_irq stays 0; KICK landing exactly at COUNT==0 -> no BARK.
REQ-029 KICK with 0x1234_5678, KICK with pstrb=4'h3, read of 0x20, write of COUNT -> each pslverr=1, pready=1, and registers unchanged.
REQ-030 In BARK, write STATUS=0x1 -> wdt_irq=0 next cycle, state stays BARK; then EN=0 -> IDLE, COUNT frozen.
REQ-031 Drop rstn for 1 cycle while in BITE mid-access -> all outputs 0, state IDLE, LOAD=0xFFFF_FFFF.
REQ-032 WDT_LOCK_EN defined: write LOCK=0, then CTRL=1 -> pslverr=1 and EN stays 0; write LOCK=0x1ACC_E551, then CTRL=1 -> RUN.
